// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB4 word-addressed memory slave with fixed wait states, byte strobes and PSLVERR
module apb_slave_mem #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                      pclk_i,
  input  logic                      prst_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [ADDR_WIDTH-1:0]     paddr_i,
  input  logic [DATA_WIDTH-1:0]     pwdata_i,
  input  logic [DATA_WIDTH/8-1:0]   pstrb_i,
  output logic                      pready_o,
  output logic [DATA_WIDTH-1:0]     prdata_o,
  output logic                      pslverr_o
);
  localparam int                    NB         = DATA_WIDTH / 8;
  localparam int                    LSB        = $clog2(NB);
  localparam int                    IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH      = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [3:0]            WS         = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] offset, word_idx;
  logic [IDX_W-1:0]      idx;
  logic                  err, enter, commit;
  logic [DATA_WIDTH-1:0] wword;

  // Address decode is combinational so it is valid both at READY entry and at the commit edge
  assign offset   = paddr_i - BASE_ADDR;
  assign word_idx = offset >> LSB;
  assign idx      = word_idx[IDX_W-1:0];
  assign err      = (paddr_i < BASE_ADDR) || (word_idx >= DEPTH) || ((offset & ALIGN_MASK) != '0);

  // The access phase completes on the edge that enters READY: straight from setup, or when the wait count runs out
  assign enter  = psel_i && (((state_q == S_IDLE) && !penable_i && (WAIT_STATES == 0)) ||
                             ((state_q == S_WAIT) && penable_i && (cnt_q == 4'd1)));
  assign commit = (state_q == S_READY) && psel_i && penable_i && pwrite_i && !err;

  // Merge the strobed write bytes over the currently stored word
  always_comb begin
    wword = mem_q[idx];
    for (int k = 0; k < NB; k++) wword[8*k +: 8] = pstrb_i[k] ? pwdata_i[8*k +: 8] : wword[8*k +: 8];
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    case (state_q)
      S_IDLE: begin
        if (psel_i && !penable_i) begin
          state_d = (WAIT_STATES == 0) ? S_READY : S_WAIT;
          cnt_d   = (WAIT_STATES == 0) ? 4'd0 : WS;
        end
      end
      S_WAIT: begin
        if (!psel_i) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (penable_i) begin
          state_d = (cnt_q == 4'd1) ? S_READY : S_WAIT;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      S_READY: begin
        state_d   = S_IDLE;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (enter) begin
      pready_d  = 1'b1;
      pslverr_d = err;
      prdata_d  = (!pwrite_i && !err) ? mem_q[idx] : '0;
    end
  end

  // State, counter and response registers
  always_ff @(posedge pclk_i) begin
    if (!prst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Memory array: cleared by reset, written only on an error-free completing write
  always_ff @(posedge pclk_i) begin
    if (!prst_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (commit) begin
      mem_q[idx] <= wword;
    end
  end

  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;
  assign prdata_o  = prdata_q;
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: directed vector bench for apb_slave_mem with zero-wait and three-wait instances
module tb_apb_slave_mem;
  logic        clk = 1'b0;
  logic        prst;
  logic        psel0, psel1, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic        pready0, pready1, pslverr0, pslverr1;
  logic [31:0] prdata0, prdata1;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  always #5 clk = ~clk;

  apb_slave_mem #(.WAIT_STATES(0)) dut0 (
    .pclk_i(clk), .prst_i(prst), .psel_i(psel0), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .pready_o(pready0), .prdata_o(prdata0), .pslverr_o(pslverr0)
  );

  apb_slave_mem #(.WAIT_STATES(3)) dut1 (
    .pclk_i(clk), .prst_i(prst), .psel_i(psel1), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .pready_o(pready1), .prdata_o(prdata1), .pslverr_o(pslverr1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer starting right now (called 1 time unit after an edge); leaves the bus idle
  task automatic xfer(input bit d1, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] exp_rd, input logic exp_err,
                      input int exp_n, input string name);
    int n;
    logic rdy;
    psel0 = !d1; psel1 = d1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    step();
    penable = 1'b1;
    n = 1;
    rdy = d1 ? pready1 : pready0;
    while (!rdy && n < 40) begin
      step();
      n++;
      rdy = d1 ? pready1 : pready0;
    end
    chk({name, " ready_cycle"}, n, exp_n);
    chk({name, " prdata"}, d1 ? prdata1 : prdata0, exp_rd);
    chk({name, " pslverr"}, {31'd0, d1 ? pslverr1 : pslverr0}, {31'd0, exp_err});
    step();
    chk({name, " ready_drop"}, {31'd0, d1 ? pready1 : pready0}, 32'd0);
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 32'h08,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 32'h08,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h08,  32'h11223344, 4'h5, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h08,  32'h0,        4'h0, 32'hDE22BE44, 1'b0};
    vecs[5]  = '{1'b0, 32'h402, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 32'h400, 32'h55,       4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h00,  32'h0,        4'h0, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'h3FC, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
    vecs[10] = '{1'b1, 32'h0C,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'h0C,  32'h0,        4'h0, 32'h0,        1'b0};
    vecs[12] = '{1'b1, 32'h09,  32'h99999999, 4'hF, 32'h0,        1'b1};
    vecs[13] = '{1'b0, 32'h08,  32'h0,        4'hA, 32'hDE22BE44, 1'b0};
    prst = 1'b0; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    step();
    step();
    chk("reset pready0", {31'd0, pready0}, 32'd0);
    chk("reset pslverr0", {31'd0, pslverr0}, 32'd0);
    chk("reset prdata0", prdata0, 32'd0);
    chk("reset pready1", {31'd0, pready1}, 32'd0);
    prst = 1'b1;
    step();
    for (int i = 0; i < 14; i++)
      xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
           vecs[i].exp_rdata, vecs[i].exp_err, 1, $sformatf("vec%0d", i));
    xfer(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 4, "ws3 write");
    xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, 4, "ws3 read");
    xfer(1'b1, 1'b0, 32'h401, 32'h0, 4'h0, 32'h0, 1'b1, 4, "ws3 misaligned");
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h24; pwdata = 32'h12345678; pstrb = 4'hF;
    step();
    penable = 1'b1;
    step();
    chk("abort wait pready", {31'd0, pready1}, 32'd0);
    psel1 = 1'b0; penable = 1'b0;
    step();
    chk("abort idle pready", {31'd0, pready1}, 32'd0);
    xfer(1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 32'h0, 1'b0, 4, "abort no write");
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h28; pwdata = 32'h77; pstrb = 4'hF;
    step();
    penable = 1'b1;
    step();
    prst = 1'b0;
    step();
    chk("midreset pready", {31'd0, pready1}, 32'd0);
    chk("midreset pslverr", {31'd0, pslverr1}, 32'd0);
    chk("midreset prdata", prdata1, 32'd0);
    prst = 1'b1; psel1 = 1'b0; penable = 1'b0;
    step();
    xfer(1'b1, 1'b0, 32'h28, 32'h0, 4'h0, 32'h0, 1'b0, 4, "midreset no write");
    xfer(1'b0, 1'b0, 32'h08, 32'h0, 4'h0, 32'h0, 1'b0, 1, "reset cleared mem");
    xfer(1'b1, 1'b1, 32'h2C, 32'h0BADCAFE, 4'hF, 32'h0, 1'b0, 4, "post reset write");
    xfer(1'b1, 1'b0, 32'h2C, 32'h0, 4'h0, 32'h0BADCAFE, 1'b0, 4, "post reset read");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
